// File: rtl/chacha_block_core_if.sv
// Job/result bus of the ChaCha block core: key/nonce/counter request in,
// 512-bit keystream block out, each over its own valid/ready pair.
interface chacha_block_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] block_out;
    logic         ctr_last;
    logic         busy;

    modport master (
        output in_valid, key, nonce, ctr, out_ready,
        input  in_ready, out_valid, block_out, ctr_last, busy
    );

    modport slave (
        input  in_valid, key, nonce, ctr, out_ready,
        output in_ready, out_valid, block_out, ctr_last, busy
    );
endinterface

// File: rtl/chacha_block_core.sv
// Iterative ChaCha keystream block generator: four quarter-rounds per clock,
// alternating column/diagonal rounds, followed by the feed-forward addition.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a job; loads state and initial copy
// ROUND | one column (even r) or diagonal (odd r) round per cycle
// FINAL | feed-forward add into block_out, raise out_valid
// DONE  | hold block_out/ctr_last/out_valid until out_ready
module chacha_block_core #(
    parameter int ROUNDS = 20
) (
    input logic                clk,
    input logic                rst_n,
    chacha_block_core_if.slave bus
);

    if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and within 2..20");
    end

    localparam int RW = $clog2(ROUNDS) + 1;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   st      [16];
    logic [31:0]   init_st [16];
    logic [31:0]   nxt     [16];
    logic [31:0]   ld      [16];
    logic [RW-1:0] r;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          ctr_last_q;
    logic [511:0]  block_q;
    logic [511:0]  block_sum;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Returns {d, c, b, a} after one quarter round.
    function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {d, c, b, a};
    endfunction

    always_comb begin
        ld[0] = SIGMA0;
        ld[1] = SIGMA1;
        ld[2] = SIGMA2;
        ld[3] = SIGMA3;
        for (int k = 0; k < 8; k++) ld[4 + k] = bus.key[32*k +: 32];
        ld[12] = bus.ctr;
        for (int k = 0; k < 3; k++) ld[13 + k] = bus.nonce[32*k +: 32];
    end

    // Column lanes use (c, 4+c, 8+c, 12+c); diagonal lanes rotate rows b/c/d by 1/2/3.
    always_comb begin
        logic [127:0] qv;
        int ib, ic, id;
        qv = '0;
        ib = 0; ic = 0; id = 0;
        for (int i = 0; i < 16; i++) nxt[i] = st[i];
        for (int c = 0; c < 4; c++) begin
            if (r[0]) begin
                ib = 4  + ((c + 1) % 4);
                ic = 8  + ((c + 2) % 4);
                id = 12 + ((c + 3) % 4);
            end else begin
                ib = 4  + c;
                ic = 8  + c;
                id = 12 + c;
            end
            qv = qr(st[c], st[ib], st[ic], st[id]);
            nxt[c]  = qv[31:0];
            nxt[ib] = qv[63:32];
            nxt[ic] = qv[95:64];
            nxt[id] = qv[127:96];
        end
    end

    always_comb begin
        block_sum = '0;
        for (int i = 0; i < 16; i++) block_sum[32*i +: 32] = st[i] + init_st[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ctr_last_q  <= 1'b0;
            block_q     <= '0;
            r           <= '0;
            for (int i = 0; i < 16; i++) begin
                st[i]      <= '0;
                init_st[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        for (int i = 0; i < 16; i++) begin
                            st[i]      <= ld[i];
                            init_st[i] <= ld[i];
                        end
                        ctr_last_q <= (bus.ctr == 32'hFFFF_FFFF);
                        r          <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    for (int i = 0; i < 16; i++) st[i] <= nxt[i];
                    r <= r + RW'(1);
                    if (r == RW'(ROUNDS - 1)) state <= S_FINAL;
                end
                S_FINAL: begin
                    block_q     <= block_sum;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.block_out = block_q;
    assign bus.ctr_last  = ctr_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 block vector, ChaCha8/12
// latency, backpressure, back-to-back counter wrap and mid-job reset.
module tb_chacha_block_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    iv   = '0;
    logic [2:0]    ordy = '1;
    logic [31:0]   ctr_d [3];
    logic [255:0]  key_v;
    logic [95:0]   nonce_v;
    wire  [2:0]    ir, ov, bsy, lst;
    wire  [1535:0] blk_all;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int R = (i == 0) ? 20 : ((i == 1) ? 8 : 12);
        chacha_block_core_if ifc ();
        assign ifc.in_valid  = iv[i];
        assign ifc.key       = key_v;
        assign ifc.nonce     = nonce_v;
        assign ifc.ctr       = ctr_d[i];
        assign ifc.out_ready = ordy[i];
        assign ir[i]  = ifc.in_ready;
        assign ov[i]  = ifc.out_valid;
        assign bsy[i] = ifc.busy;
        assign lst[i] = ifc.ctr_last;
        assign blk_all[512*i +: 512] = ifc.block_out;
        chacha_block_core #(.ROUNDS(R)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    localparam logic [511:0] RFC_BLOCK = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] qr_m(input logic [511:0] s, input int a, input int b,
                                          input int c, input int d);
        logic [511:0] t;
        t = s;
        t[32*a +: 32] = t[32*a +: 32] + t[32*b +: 32];
        t[32*d +: 32] = rol(t[32*d +: 32] ^ t[32*a +: 32], 16);
        t[32*c +: 32] = t[32*c +: 32] + t[32*d +: 32];
        t[32*b +: 32] = rol(t[32*b +: 32] ^ t[32*c +: 32], 12);
        t[32*a +: 32] = t[32*a +: 32] + t[32*b +: 32];
        t[32*d +: 32] = rol(t[32*d +: 32] ^ t[32*a +: 32], 8);
        t[32*c +: 32] = t[32*c +: 32] + t[32*d +: 32];
        t[32*b +: 32] = rol(t[32*b +: 32] ^ t[32*c +: 32], 7);
        return t;
    endfunction

    function automatic logic [511:0] chacha_model(input int rounds, input logic [255:0] k,
                                                  input logic [95:0] nn, input logic [31:0] c);
        logic [511:0] x0, x, res;
        x0 = {nn, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        x = x0;
        for (int rr = 0; rr < rounds; rr += 2) begin
            x = qr_m(x, 0, 4, 8, 12);  x = qr_m(x, 1, 5, 9, 13);
            x = qr_m(x, 2, 6, 10, 14); x = qr_m(x, 3, 7, 11, 15);
            x = qr_m(x, 0, 5, 10, 15); x = qr_m(x, 1, 6, 11, 12);
            x = qr_m(x, 2, 7, 8, 13);  x = qr_m(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[32*i +: 32] + x0[32*i +: 32];
        return res;
    endfunction

    int cyc = 0;
    int acc_prev = 0;
    int acc_gap = 0;
    int acc_cnt = 0;
    always @(posedge clk) begin
        if (rst_n && iv[0] && ir[0]) begin
            acc_gap  = cyc - acc_prev;
            acc_prev = cyc;
            acc_cnt++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int j, input logic [31:0] c, input int exp_lat,
                           input logic exp_last, input logic [511:0] exp_blk);
        int n;
        n = 0;
        while (!ir[j] && n < 50) begin tick(); n++; end
        check_eq("ready_before_job", ir[j], 1'b1);
        ctr_d[j] = c;
        iv[j] = 1'b1;
        tick();
        iv[j] = 1'b0;
        ctr_d[j] = 32'hdead_beef;
        check_eq("busy_after_accept", bsy[j], 1'b1);
        check_eq("ready_low_after_accept", ir[j], 1'b0);
        n = 0;
        while (!ov[j] && n < 100) begin tick(); n++; end
        check_eq("latency", n, exp_lat);
        check_eq("block", blk_all[512*j +: 512], exp_blk);
        check_eq("ctr_last", lst[j], exp_last);
        check_eq("busy_in_done", bsy[j], 1'b0);
        if (ordy[j]) begin
            tick();
            check_eq("out_valid_cleared", ov[j], 1'b0);
            check_eq("ready_after_handshake", ir[j], 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] snap;
        logic         snap_last;
        logic         seen;
        int           n, acc_before;

        for (int k = 0; k < 32; k++) key_v[8*k +: 8] = 8'(k);
        nonce_v = {32'h0000_0000, 32'h4a00_0000, 32'h0900_0000};
        for (int i = 0; i < 3; i++) ctr_d[i] = '0;

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_in_ready", ir[i], 1'b1);
            check_eq("rst_out_valid", ov[i], 1'b0);
            check_eq("rst_busy", bsy[i], 1'b0);
            check_eq("rst_ctr_last", lst[i], 1'b0);
            check_eq("rst_block", blk_all[512*i +: 512], '0);
        end
        rst_n = 1'b1;
        tick();

        run_job(0, 32'd1, 21, 1'b0, RFC_BLOCK);
        run_job(1, 32'd1, 9, 1'b0, chacha_model(8, key_v, nonce_v, 32'd1));
        run_job(2, 32'd1, 13, 1'b0, chacha_model(12, key_v, nonce_v, 32'd1));

        // Backpressure with a wrap counter so ctr_last is visibly held high.
        ordy[0] = 1'b0;
        run_job(0, 32'hFFFF_FFFF, 21, 1'b1, chacha_model(20, key_v, nonce_v, 32'hFFFF_FFFF));
        snap = blk_all[511:0];
        snap_last = lst[0];
        acc_before = acc_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            iv[0] = (k == 3);
            check_eq("bp_out_valid", ov[0], 1'b1);
            check_eq("bp_block", blk_all[511:0], snap);
            check_eq("bp_ctr_last", lst[0], snap_last);
            check_eq("bp_in_ready", ir[0], 1'b0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        check_eq("bp_release_ready", ir[0], 1'b1);
        check_eq("bp_release_valid", ov[0], 1'b0);
        check_eq("bp_pulse_ignored", acc_cnt, acc_before);
        check_eq("bp_not_busy", bsy[0], 1'b0);

        // Back-to-back: in_valid held high across two jobs.
        ctr_d[0] = 32'hFFFF_FFFE;
        iv[0] = 1'b1;
        tick();
        ctr_d[0] = 32'hFFFF_FFFF;
        n = 0;
        while (!ov[0] && n < 100) begin tick(); n++; end
        check_eq("b2b_lat0", n, 21);
        check_eq("b2b_block0", blk_all[511:0], chacha_model(20, key_v, nonce_v, 32'hFFFF_FFFE));
        check_eq("b2b_last0", lst[0], 1'b0);
        tick();
        tick();
        iv[0] = 1'b0;
        check_eq("b2b_accept_gap", acc_gap, 23);
        check_eq("b2b_second_busy", bsy[0], 1'b1);
        n = 0;
        while (!ov[0] && n < 100) begin tick(); n++; end
        check_eq("b2b_lat1", n, 21);
        check_eq("b2b_block1", blk_all[511:0], chacha_model(20, key_v, nonce_v, 32'hFFFF_FFFF));
        check_eq("b2b_last1", lst[0], 1'b1);
        tick();

        // Reset at round 10 aborts the job.
        ctr_d[0] = 32'd1;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (10) tick();
        check_eq("mid_busy", bsy[0], 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_abort_ready", ir[0], 1'b1);
        check_eq("rst_abort_busy", bsy[0], 1'b0);
        tick();
        check_eq("post_rst_ready", ir[0], 1'b1);
        check_eq("post_rst_busy", bsy[0], 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (ov[0]) seen = 1'b1;
            tick();
        end
        check_eq("no_out_after_rst", seen, 1'b0);

        run_job(0, 32'd1, 21, 1'b0, RFC_BLOCK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
